ats21_cmd_issuer: RTL and testbench



---
 rtl/ats21_pkg.sv | 31 +++
 rtl/ats21_cmd_issuer_alarm_capture.sv | 33 +++
 rtl/ats21_cmd_issuer.sv | 139 +++++++++++++
 tb/tb_ats21_cmd_issuer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ats21_pkg.sv
// Shared ATS21 definitions: opcodes, status encoding, port sizing constants,
// and the issuer FSM state type.
package ats21_pkg;

    localparam int NUM_ALARMS = 24;
    localparam int NUM_CLOCKS = 16;

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_SET_CLK   = 3'b001,
        OP_EN_CLK    = 3'b010,
        OP_MODE      = 3'b011,
        OP_SET_ALARM = 3'b101,
        OP_SET_TIMER = 3'b110,
        OP_EN_ALARM  = 3'b111
    } ats21_opcode_e;

    typedef enum logic {
        ST_NACK = 1'b0,
        ST_ACK  = 1'b1
    } ats21_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WAIT,
        S_RESP
    } issuer_state_e;

endpackage

// File: rtl/ats21_cmd_issuer_alarm_capture.sv
// Per-alarm rising-edge detection with sticky pending and overrun flags.
// A level held for several cycles is a single event; a set in the same cycle
// as a clear wins.
module ats21_alarm_capture #(
    parameter int NUM_ALARMS = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_ALARMS-1:0] data_in,
    input  logic [NUM_ALARMS-1:0] alarm_clear,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic [NUM_ALARMS-1:0] alarm_overrun
);

    logic [NUM_ALARMS-1:0] data_prev;
    logic [NUM_ALARMS-1:0] rise;

    assign rise = data_in & ~data_prev;

    // Edge history plus sticky flags; overrun looks at pending before this cycle's update.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_prev     <= '0;
            alarm_pending <= '0;
            alarm_overrun <= '0;
        end else begin
            data_prev     <= data_in;
            alarm_pending <= (alarm_pending & ~alarm_clear) | rise;
            alarm_overrun <= (alarm_overrun & ~alarm_clear) | (rise & alarm_pending);
        end
    end

endmodule

// File: rtl/ats21_cmd_issuer.sv
// ATS21 client command issuer: accepts 32-bit instructions, sends them as a
// high/low pair of 16-bit beats, samples Ack/Nack after RSP_LAT cycles and
// returns a one-cycle response. Also hosts the alarm event capture.
// Optional feature macro: ATS21_ISSUER_RETRY_EN (re-issue on Nack up to MAX_RETRY).
module ats21_cmd_issuer
    import ats21_pkg::*;
#(
    parameter int RSP_LAT    = 2,
    parameter int MAX_RETRY  = 3,
    parameter int NUM_ALARMS = ats21_pkg::NUM_ALARMS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [31:0]                    cmd_word,
    output logic                           rsp_valid,
    output logic                           rsp_ack,
    output logic [$clog2(MAX_RETRY+1):0]   rsp_tries,
    output logic                           req,
    output logic [15:0]                    ctrl,
    input  logic                           stat_in,
    input  logic [NUM_ALARMS-1:0]          data_in,
    output logic [NUM_ALARMS-1:0]          alarm_pending,
    output logic [NUM_ALARMS-1:0]          alarm_overrun,
    input  logic [NUM_ALARMS-1:0]          alarm_clear
);

    localparam int TRY_W = $clog2(MAX_RETRY + 1) + 1;
    localparam int CNT_W = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RSP_LAT - 1);
`ifdef ATS21_ISSUER_RETRY_EN
    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_RETRY);
`endif

    issuer_state_e     state;
    logic [31:0]       word_q;
    logic [TRY_W-1:0]  tries;
    logic [CNT_W-1:0]  wait_cnt;

    // Command FSM; every output is assigned on the transition into the state that owns it,
    // so req/ctrl are on the bus during the cycle the FSM sits in HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            word_q    <= '0;
            tries     <= '0;
            wait_cnt  <= '0;
            cmd_ready <= 1'b0;
            req       <= 1'b0;
            ctrl      <= '0;
            rsp_valid <= 1'b0;
            rsp_ack   <= 1'b0;
            rsp_tries <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        word_q    <= cmd_word;
                        if (ats21_opcode_e'(cmd_word[31:29]) == OP_NOP) begin
                            tries     <= '0;
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_ack   <= 1'b1;
                            rsp_tries <= '0;
                        end else begin
                            tries <= TRY_W'(1);
                            state <= S_HI;
                            req   <= 1'b1;
                            ctrl  <= cmd_word[31:16];
                        end
                    end
                end
                S_HI: begin
                    ctrl  <= word_q[15:0];
                    state <= S_LO;
                end
                S_LO: begin
                    req      <= 1'b0;
                    ctrl     <= '0;
                    wait_cnt <= WAIT_LOAD;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end else if (ats21_status_e'(stat_in) == ST_ACK) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_ack   <= 1'b1;
                        rsp_tries <= tries;
                    end else begin
`ifdef ATS21_ISSUER_RETRY_EN
                        if (tries < TRY_MAX) begin
                            // Re-issue straight from the sample point with the untouched latched word.
                            tries <= tries + TRY_W'(1);
                            state <= S_HI;
                            req   <= 1'b1;
                            ctrl  <= word_q[31:16];
                        end else begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_ack   <= 1'b0;
                            rsp_tries <= tries;
                        end
`else
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_ack   <= 1'b0;
                        rsp_tries <= tries;
`endif
                    end
                end
                S_RESP: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    ats21_alarm_capture #(
        .NUM_ALARMS (NUM_ALARMS)
    ) u_alarm_capture (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .alarm_clear   (alarm_clear),
        .alarm_pending (alarm_pending),
        .alarm_overrun (alarm_overrun)
    );

endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// Directed bench for ats21_cmd_issuer with default parameters
// (RSP_LAT=2, MAX_RETRY=3, NUM_ALARMS=24). Follows ATS21_ISSUER_RETRY_EN.
module tb_ats21_cmd_issuer;

    localparam int NA = 24;

`ifdef ATS21_ISSUER_RETRY_EN
    localparam int NACK_TRIES  = 3;
    localparam int NACK_BURSTS = 3;
    localparam int NACK_LAT    = 13;
`else
    localparam int NACK_TRIES  = 1;
    localparam int NACK_BURSTS = 1;
    localparam int NACK_LAT    = 5;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   cmd_word = '0;
    logic          rsp_valid;
    logic          rsp_ack;
    logic [2:0]    rsp_tries;
    logic          req;
    logic [15:0]   ctrl;
    logic          stat_in = 1'b0;
    logic [NA-1:0] data_in = '0;
    logic [NA-1:0] alarm_pending;
    logic [NA-1:0] alarm_overrun;
    logic [NA-1:0] alarm_clear = '0;

    int checks = 0;
    int failures = 0;

    ats21_cmd_issuer dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_word      (cmd_word),
        .rsp_valid     (rsp_valid),
        .rsp_ack       (rsp_ack),
        .rsp_tries     (rsp_tries),
        .req           (req),
        .ctrl          (ctrl),
        .stat_in       (stat_in),
        .data_in       (data_in),
        .alarm_pending (alarm_pending),
        .alarm_overrun (alarm_overrun),
        .alarm_clear   (alarm_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("cmd_ready timeout", 32'(cmd_ready), 32'd1);
    endtask

    typedef struct {
        logic [31:0] word;
        logic        stat;
        logic        exp_ack;
        int          exp_tries;
        int          exp_bursts;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    // Issue one instruction, then follow the bus cycle by cycle until the response.
    task automatic run_vec(input int idx, input vec_t v);
        int cyc, run, bursts;
        bit done;
        logic [15:0] hi, lo;
        hi = v.word[31:16];
        lo = v.word[15:0];
        wait_ready();
        cmd_word  = v.word;
        stat_in   = v.stat;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_word  = 32'hDEAD_BEEF;
        cyc = 1; run = 0; bursts = 0; done = 0;
        while (!done && cyc < 60) begin
            if (req) begin
                run++;
                if (run == 1) bursts++;
                chk($sformatf("v%0d c%0d beat", idx, cyc), 32'(ctrl), 32'(run == 1 ? hi : lo));
            end else begin
                if (run != 0) chk($sformatf("v%0d burst length", idx), 32'(run), 32'd2);
                run = 0;
                chk($sformatf("v%0d c%0d ctrl idle", idx, cyc), 32'(ctrl), 32'd0);
            end
            chk($sformatf("v%0d c%0d cmd_ready busy", idx, cyc), 32'(cmd_ready), 32'd0);
            if (rsp_valid) done = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk($sformatf("v%0d response seen", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.exp_lat));
        chk($sformatf("v%0d rsp_ack", idx), 32'(rsp_ack), 32'(v.exp_ack));
        chk($sformatf("v%0d rsp_tries", idx), 32'(rsp_tries), 32'(v.exp_tries));
        chk($sformatf("v%0d bursts", idx), 32'(bursts), 32'(v.exp_bursts));
        @(negedge clk);
        chk($sformatf("v%0d rsp one cycle", idx), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d ready after resp", idx), 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] wa, wb;
        logic [31:0] e_ctrl;
        logic        e_req, e_rsp, e_rdy;

        vecs[0] = '{32'h2400_0010, 1'b1, 1'b1, 1, 1, 5};
        vecs[1] = '{32'h0000_0000, 1'b1, 1'b1, 0, 0, 1};
        vecs[2] = '{32'hA5A5_1234, 1'b0, 1'b0, NACK_TRIES, NACK_BURSTS, NACK_LAT};
        vecs[3] = '{32'h1FFF_FFFF, 1'b0, 1'b1, 0, 0, 1};
        vecs[4] = '{32'hE123_4567, 1'b1, 1'b1, 1, 1, 5};
        vecs[5] = '{32'h6000_0001, 1'b0, 1'b0, NACK_TRIES, NACK_BURSTS, NACK_LAT};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset req", 32'(req), 32'd0);
        chk("reset ctrl", 32'(ctrl), 32'd0);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_ack", 32'(rsp_ack), 32'd0);
        chk("reset rsp_tries", 32'(rsp_tries), 32'd0);
        chk("reset pending", 32'(alarm_pending), 32'd0);
        chk("reset overrun", 32'(alarm_overrun), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready after reset", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Alarm capture
        data_in = NA'(1) << 5;
        @(negedge clk);
        chk("alarm pend first", 32'(alarm_pending), 32'h20);
        chk("alarm ovr first", 32'(alarm_overrun), 32'h0);
        @(negedge clk);
        data_in = '0;
        chk("alarm held level pend", 32'(alarm_pending), 32'h20);
        chk("alarm held level ovr", 32'(alarm_overrun), 32'h0);
        @(negedge clk);
        data_in = NA'(1) << 5;
        @(negedge clk);
        chk("alarm second pend", 32'(alarm_pending), 32'h20);
        chk("alarm second ovr", 32'(alarm_overrun), 32'h20);
        @(negedge clk);
        data_in = '0;
        @(negedge clk);
        data_in     = NA'(1) << 5;
        alarm_clear = NA'(1) << 5;
        @(negedge clk);
        alarm_clear = '0;
        chk("alarm set wins pend", 32'(alarm_pending), 32'h20);
        chk("alarm set wins ovr", 32'(alarm_overrun), 32'h20);
        @(negedge clk);
        data_in     = '0;
        alarm_clear = '1;
        @(negedge clk);
        alarm_clear = '0;
        chk("alarm clear pend", 32'(alarm_pending), 32'h0);
        chk("alarm clear ovr", 32'(alarm_overrun), 32'h0);
        data_in = (NA'(1) << 23) | NA'(1);
        @(negedge clk);
        chk("alarm edge bits pend", 32'(alarm_pending), 32'h80_0001);
        chk("alarm edge bits ovr", 32'(alarm_overrun), 32'h0);
        data_in     = '0;
        alarm_clear = NA'(1);
        @(negedge clk);
        alarm_clear = '0;
        chk("alarm partial clear", 32'(alarm_pending), 32'h80_0000);

        // Reset during the LO beat
        wait_ready();
        stat_in   = 1'b1;
        cmd_word  = 32'h3456_789A;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort hi req", 32'(req), 32'd1);
        @(negedge clk);
        chk("abort lo ctrl", 32'(ctrl), 32'h789A);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort req drop", 32'(req), 32'd0);
        chk("abort ctrl drop", 32'(ctrl), 32'd0);
        chk("abort ready in reset", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("abort ready after", 32'(cmd_ready), 32'd1);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("abort no rsp c%0d", c), 32'(rsp_valid), 32'd0);
            chk($sformatf("abort no req c%0d", c), 32'(req), 32'd0);
            @(negedge clk);
        end

        // Back-to-back with cmd_valid held high
        wa = 32'h2400_0010;
        wb = 32'h5123_ABCD;
        wait_ready();
        stat_in   = 1'b1;
        cmd_word  = wa;
        cmd_valid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            e_req  = (c == 1 || c == 2 || c == 7 || c == 8);
            e_rsp  = (c == 5 || c == 11);
            e_rdy  = (c == 6);
            case (c)
                1:       e_ctrl = 32'(wa[31:16]);
                2:       e_ctrl = 32'(wa[15:0]);
                7:       e_ctrl = 32'(wb[31:16]);
                8:       e_ctrl = 32'(wb[15:0]);
                default: e_ctrl = 32'd0;
            endcase
            chk($sformatf("b2b c%0d req", c), 32'(req), 32'(e_req));
            chk($sformatf("b2b c%0d ctrl", c), 32'(ctrl), e_ctrl);
            chk($sformatf("b2b c%0d rsp_valid", c), 32'(rsp_valid), 32'(e_rsp));
            chk($sformatf("b2b c%0d cmd_ready", c), 32'(cmd_ready), 32'(e_rdy));
            if (e_rsp) chk($sformatf("b2b c%0d rsp_ack", c), 32'(rsp_ack), 32'd1);
            if (c == 1) cmd_word = wb;
            if (c == 7) cmd_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
